// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } owner_t;

  localparam int PORT_CPU     = 0;
  localparam int PORT_LD      = 1;
  localparam int DEF_MAX_HOLD = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; on contention the port that was not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port dmem between the core (port 0) and the loader (port 1).
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N        = 16,
  parameter int AW       = 16,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [N-1:0]  wdata0,
  output logic          gnt0,
  output logic          stall0,
  output logic          rvalid0,
  output logic [N-1:0]  rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [N-1:0]  wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [N-1:0]  rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  owner_t        owner;
  logic          last;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    req;
  logic [1:0]    rr_gnt;
  logic [1:0]    gnt;

  assign req = {req1, req0};

  rr_pick2 u_rr (
    .req  (req),
    .last (last),
    .gnt  (rr_gnt)
  );

  // Owner keeps the port unless its hold budget is spent while the other side waits.
  always_comb begin
    gnt = rr_gnt;
    if (owner == OWN0 && req0 && (!req1 || hold_cnt < HOLD_MAX))
      gnt = 2'b01;
    else if (owner == OWN1 && req1 && (!req0 || hold_cnt < HOLD_MAX))
      gnt = 2'b10;
    if (!reset_n)
      gnt = '0;
  end

  assign gnt0   = gnt[PORT_CPU];
  assign gnt1   = gnt[PORT_LD];
  assign stall0 = req0 & ~gnt0;

  always_comb begin
    mem_addr  = addr0;
    mem_wdata = wdata0;
    mem_we    = gnt0 & we0;
    if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end
    if (!reset_n) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= OWN_NONE;
      last     <= 1'b1;
      hold_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      if (|gnt)
        last <= gnt1;

      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0)
        rdata0 <= mem_rdata;
      if (gnt1 & ~we1)
        rdata1 <= mem_rdata;

      // Acquiring grant already counts toward the hold budget if the other side is waiting.
      case (owner)
        OWN_NONE: begin
          if (gnt0 && lock0) begin
            owner    <= OWN0;
            hold_cnt <= req1 ? HW'(1) : '0;
          end else if (gnt1 && lock1) begin
            owner    <= OWN1;
            hold_cnt <= req0 ? HW'(1) : '0;
          end
        end
        OWN0: begin
          if (gnt0 && lock0) begin
            if (req1 && hold_cnt != HOLD_MAX)
              hold_cnt <= hold_cnt + HW'(1);
          end else begin
            owner    <= OWN_NONE;
            hold_cnt <= '0;
          end
        end
        OWN1: begin
          if (gnt1 && lock1) begin
            if (req0 && hold_cnt != HOLD_MAX)
              hold_cnt <= hold_cnt + HW'(1);
          end else begin
            owner    <= OWN_NONE;
            hold_cnt <= '0;
          end
        end
        default: begin
          owner    <= OWN_NONE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0)
        grant_cnt0 <= sat_inc16(grant_cnt0);
      if (gnt1)
        grant_cnt1 <= sat_inc16(grant_cnt1);
      if (req0 && req1)
        conflict_cnt <= sat_inc16(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural dmem.
module tb_dmem_arbiter;
  localparam int N  = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [N-1:0]  wdata0, wdata1;
  logic          gnt0, gnt1, stall0, rvalid0, rvalid1;
  logic [N-1:0]  rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [N-1:0]  mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  logic [N-1:0] ram [0:255];
  logic         preload;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram[8'h30] <= 16'hBEEF;
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  dmem_arbiter #(.N(N), .AW(AW), .MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .stall0(stall0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [N-1:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [N-1:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic e0;
    reset_n = 1'b0;
    preload = 1'b1;
    idle();

    // Reset state, with a write attempted while in reset
    @(negedge clk);
    preload = 1'b0;
    drive0(1'b1, 1'b1, 1'b0, 16'h0011, 16'h1234);
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_stall0", stall0, 1);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    #1;
    check("rst_no_write", ram[8'h11], 0);

    // Single core reads
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b0, 16'h001F, '0);
    #1;
    check("t1_gnt0", gnt0, 1);
    check("t1_gnt1", gnt1, 0);
    check("t1_stall0", stall0, 0);
    check("t1_mem_addr", mem_addr, 16'h001F);
    check("t1_mem_we", mem_we, 0);
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b0, 16'h0030, '0);
    #1;
    check("t1_rvalid0", rvalid0, 1);
    check("t1_rdata0", rdata0, 16'h0000);
    check("t1_gnt0_b", gnt0, 1);
    @(negedge clk);
    idle();
    #1;
    check("t1_rvalid0_b", rvalid0, 1);
    check("t1_rdata0_b", rdata0, 16'hBEEF);
    @(negedge clk);
    #1;
    check("t1_rvalid0_drop", rvalid0, 0);
    check("t1_rdata0_hold", rdata0, 16'hBEEF);

    // Single loader read
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b0, 16'h0030, '0);
    #1;
    check("p1_gnt1", gnt1, 1);
    check("p1_mem_addr", mem_addr, 16'h0030);
    @(negedge clk);
    idle();
    #1;
    check("p1_rvalid1", rvalid1, 1);
    check("p1_rdata1", rdata1, 16'hBEEF);
    check("p1_rvalid0", rvalid0, 0);

    // Contention without lock alternates, starting with port 0 (last grant was port 1)
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive0(1'b1, 1'b1, 1'b0, 16'(16'h0040 + i), 16'(16'h1000 + i));
      drive1(1'b1, 1'b1, 1'b0, 16'(16'h0080 + i), 16'(16'h2000 + i));
      #1;
      e0 = (i % 2 == 0);
      check("t2_gnt0", gnt0, e0);
      check("t2_gnt1", gnt1, !e0);
      check("t2_stall0", stall0, !e0);
      check("t2_mem_we", mem_we, 1);
      check("t2_mem_addr", mem_addr, e0 ? 16'(16'h0040 + i) : 16'(16'h0080 + i));
    end
    @(negedge clk);
    idle();
    #1;
    check("t2_ram40", ram[8'h40], 16'h1000);
    check("t2_ram41", ram[8'h41], 16'h0000);
    check("t2_ram42", ram[8'h42], 16'h1002);
    check("t2_ram80", ram[8'h80], 16'h0000);
    check("t2_ram81", ram[8'h81], 16'h2001);
    check("t2_ram83", ram[8'h83], 16'h2003);

    // Core write so that the loader wins the next contention
    @(negedge clk);
    drive0(1'b1, 1'b1, 1'b0, 16'h00A0, 16'h5555);
    #1;
    check("t3_pre_gnt0", gnt0, 1);

    // Locked loader burst against a waiting core: 4 grants then forced release
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive0(1'b1, 1'b0, 1'b0, 16'h0030, '0);
      drive1(1'b1, 1'b1, 1'b1, 16'(16'h0054 + i), 16'(16'h0096 + i));
      #1;
      check("t3_gnt1", gnt1, i < 4);
      check("t3_gnt0", gnt0, i == 4);
    end
    @(negedge clk);
    idle();
    #1;
    check("t3_rvalid0", rvalid0, 1);
    check("t3_rdata0", rdata0, 16'hBEEF);
    check("t3_ram54", ram[8'h54], 16'h0096);
    check("t3_ram57", ram[8'h57], 16'h0099);
    check("t3_ram58", ram[8'h58], 16'h0000);

    // Locked loader alone keeps the port; core arrives and waits MAX_HOLD grants
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive1(1'b1, 1'b1, 1'b1, 16'(16'h00B0 + i), 16'(16'h3000 + i));
      #1;
      check("t4_solo_gnt1", gnt1, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive0(1'b1, 1'b0, 1'b0, 16'h0030, '0);
      drive1(1'b1, 1'b1, 1'b1, 16'(16'h00B6 + i), 16'(16'h3006 + i));
      #1;
      check("t4_gnt1", gnt1, i < 4);
      check("t4_gnt0", gnt0, i == 4);
      check("t4_stall0", stall0, i < 4);
    end
    @(negedge clk);
    idle();

    // Reset right after a read grant drops rvalid and blocks writes
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b0, 16'h001F, '0);
    #1;
    check("t5_gnt0", gnt0, 1);
    @(posedge clk);
    #1;
    check("t5_rvalid_pre", rvalid0, 1);
    reset_n = 1'b0;
    drive0(1'b1, 1'b1, 1'b0, 16'h00C0, 16'h7777);
    #1;
    check("t5_rvalid0", rvalid0, 0);
    check("t5_mem_we", mem_we, 0);
    check("t5_gnt0", gnt0, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive0(1'b1, 1'b1, 1'b0, 16'h00C2, 16'h0A0A);
    drive1(1'b1, 1'b1, 1'b0, 16'h00C4, 16'h0B0B);
    #1;
    check("t5_ramC0", ram[8'hC0], 16'h0000);
    check("t5_first_gnt0", gnt0, 1);
    check("t5_first_gnt1", gnt1, 0);
    @(negedge clk);
    #1;
    check("t5_second_gnt1", gnt1, 1);
    @(negedge clk);
    idle();

`ifdef DMEM_ARB_STATS_EN
    // Statistics over 10 contention cycles after a fresh reset
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t6_rst_conflict", conflict_cnt, 0);
    check("t6_rst_g0", grant_cnt0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive0(1'b1, 1'b0, 1'b0, 16'h0030, '0);
      drive1(1'b1, 1'b0, 1'b0, 16'h001F, '0);
    end
    @(negedge clk);
    idle();
    #1;
    check("t6_conflict", conflict_cnt, 10);
    check("t6_g0", grant_cnt0, 5);
    check("t6_g1", grant_cnt1, 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
